io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter DEPTH, default 4 (power of two, >=2); entry count of each of the two word FIFOs.
REQ-002 clock  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low; clears all state.
REQ-004 io_read  input  1  load/frame-get request level from the IO controller.
REQ-005 io_write  input  1  store/frame-put request level from the IO controller.
REQ-006 selframe  input  1  qualifies the request as a frame access.
REQ-007 wdata  input  16  store/frame-put data, i.e. the accumulator value.
REQ-008 ioack  output  1  four-phase acknowledge, registered.
REQ-009 rdata  output  16  load/frame-get result, registered.
REQ-010 in_valid, in_data[15:0], in_ready  in/in/out  1/16/1  host word stream feeding loads.
REQ-011 out_valid, out_data[15:0], out_ready  out/out/in  1/16/1  host word stream carrying stores.
REQ-012 frame_tick  input  1  single-cycle pulse advancing the frame counter.
REQ-013 frame_out  output  16  last frame-put value; frame_strobe  output  1  one-cycle pulse on frame-put.
REQ-014 proto_err  output  1  sticky flag: io_read and io_write sampled high together.

Function
REQ-015 FSM states: IDLE, WAIT, ACK.
- IDLE: req = io_read|io_write sampled high -> WAIT.
- WAIT: operation performed in the first cycle its resource is available -> ACK, ioack<=1 in that same edge.
- ACK: io_read=io_write=0 sampled -> ioack<=0 -> IDLE.
REQ-016 Load (io_read, !selframe): WAIT pops the input FIFO head into rdata when count>0; otherwise stalls indefinitely.
REQ-017 Store (io_write, !selframe): WAIT pushes wdata into the output FIFO when not full; otherwise stalls.
REQ-018 Frame-get (io_read, selframe): rdata<=frame_count; never stalls.
REQ-019 Frame-put (io_write, selframe): frame_out<=wdata and frame_strobe=1 for exactly one cycle; never stalls.
REQ-020 Minimum latency: request sampled at edge N, ioack high after edge N+2; rdata valid no later than ioack rise and held until the next load/frame-get completes.
REQ-021 io_read and io_write both high in IDLE: proto_err<=1, no FIFO/frame side effect, acknowledge normally.
REQ-022 Within WAIT/ACK, changes of selframe, wdata, or request lines other than full release are ignored; the operation is latched at IDLE->WAIT.
REQ-023 in_ready = input FIFO not full; push on in_valid&in_ready; push and pop in the same cycle are both honoured, count unchanged.
REQ-024 out_valid = output FIFO not empty; out_data = head; pop on out_valid&out_ready; simultaneous push/pop allowed when not full.
REQ-025 FIFO pointers are log2(DEPTH) bits with natural wrap; count is log2(DEPTH)+1 bits.
REQ-026 frame_count is 16 bits, +1 per frame_tick, wraps 0xFFFF->0x0000; a tick coinciding with frame-get returns the pre-increment value.

Reset
REQ-027 On reset low: state=IDLE, ioack=0, rdata=0, frame_out=0, frame_strobe=0, frame_count=0, proto_err=0, both FIFOs empty (in_ready=1, out_valid=0).
REQ-028 Reset asserted mid-handshake abandons the operation; a FIFO push/pop not already performed does not occur.

Structure
REQ-029 A shared package holds state encodings (IDLE/WAIT/ACK) and the 16-bit word width constant.
REQ-030 One sub-module, io_word_fifo (DEPTH parameter, push/pop/full/empty/count), instantiated twice.

Verification
REQ-031 Host pushes 0x1234, load request -> ioack rises 2 cycles after request, rdata=0x1234, in FIFO empty; drop io_read -> ioack low next cycle.
REQ-032 Load with empty FIFO, host pushes 0xBEEF after 10 cycles -> ioack stays 0 until push, then rdata=0xBEEF.
REQ-033 DEPTH stores of 1..4 with out_ready=0, fifth store 0x0005 -> fifth stalls; one out_ready pop (data 0x0001) -> fifth acked, FIFO again full.
REQ-034 frame_count at 0xFFFF, frame_tick with frame-get -> rdata=0xFFFF, frame_count=0x0000; frame-put 0x00AA -> frame_out=0x00AA, single-cycle frame_strobe.
REQ-035 io_read and io_write high together -> proto_err=1, acked, FIFO counts unchanged.
REQ-036 Reset asserted in WAIT during a stalled store -> ioack=0, state IDLE, output FIFO empty, proto_err=0.

Source files
------------

// File: rtl/io_responder_pkg.sv
// Shared definitions for the IO responder: word width, handshake states and
// the operation kinds latched when a request is accepted.
package io_responder_pkg;

   localparam int unsigned WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'd0,
      OP_STORE = 3'd1,
      OP_FGET  = 3'd2,
      OP_FPUT  = 3'd3,
      OP_ERR   = 3'd4
   } op_t;

   // Both request lines high is a protocol error; it is acknowledged with no side effect.
   function automatic op_t op_decode(input logic rd, input logic wr, input logic sf);
      if (rd && wr)
         return OP_ERR;
      else if (rd)
         return sf ? OP_FGET : OP_LOAD;
      else
         return sf ? OP_FPUT : OP_STORE;
   endfunction

endpackage

// File: rtl/io_word_fifo.sv
// Small word FIFO with natural-wrap pointers; pushes when full and pops when
// empty are ignored.
module io_word_fifo
   import io_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WORD_W-1:0]        push_data,
   input  logic                     pop,
   output logic [WORD_W-1:0]        pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/io_responder.sv
// Four-phase IO responder: serves loads/stores from host word FIFOs and
// frame-get/frame-put against a free-running frame counter.
module io_responder
   import io_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_read,
   input  logic              io_write,
   input  logic              selframe,
   input  logic [WORD_W-1:0] wdata,
   output logic              ioack,
   output logic [WORD_W-1:0] rdata,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              frame_tick,
   output logic [WORD_W-1:0] frame_out,
   output logic              frame_strobe,
   output logic              proto_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   state_t            state_q, state_d;
   op_t               op_q, op_d;
   logic [WORD_W-1:0] opd_q, opd_d;
   logic              rd_q, wr_q, sf_q;
   logic [WORD_W-1:0] wdata_q;
   logic [WORD_W-1:0] frame_count;

   logic              in_full, in_empty, in_pop;
   logic [WORD_W-1:0] in_head;
   logic [AW:0]       in_count;
   logic              out_full, out_empty, out_push;
   logic [AW:0]       out_count;

   logic              done;
   logic              set_err;

   io_word_fifo #(.DEPTH(DEPTH)) u_in_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (in_valid),
      .push_data (in_data),
      .pop       (in_pop),
      .pop_data  (in_head),
      .full      (in_full),
      .empty     (in_empty),
      .count     (in_count)
   );

   io_word_fifo #(.DEPTH(DEPTH)) u_out_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (out_push),
      .push_data (opd_q),
      .pop       (out_ready),
      .pop_data  (out_data),
      .full      (out_full),
      .empty     (out_empty),
      .count     (out_count)
   );

   assign in_ready  = !in_full;
   assign out_valid = !out_empty;

   a_in_count:  assert property (@(posedge clock) disable iff (!reset) in_empty == (in_count == '0));
   a_out_count: assert property (@(posedge clock) disable iff (!reset) out_empty == (out_count == '0));

   // Request lines pass through one register stage, so acceptance sees them one edge late.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         sf_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         rd_q    <= io_read;
         wr_q    <= io_write;
         sf_q    <= selframe;
         wdata_q <= wdata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         op_q    <= OP_LOAD;
         opd_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         opd_q   <= opd_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opd_d    = opd_q;
      in_pop   = 1'b0;
      out_push = 1'b0;
      done     = 1'b0;
      set_err  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_q || wr_q) begin
               state_d = WAIT;
               op_d    = op_decode(rd_q, wr_q, sf_q);
               opd_d   = wdata_q;
               set_err = rd_q && wr_q;
            end
         end
         WAIT: begin
            case (op_q)
               OP_LOAD:  done = !in_empty;
               OP_STORE: done = !out_full;
               default:  done = 1'b1;
            endcase
            in_pop   = done && (op_q == OP_LOAD);
            out_push = done && (op_q == OP_STORE);
            if (done)
               state_d = ACK;
         end
         ACK: begin
            if (!io_read && !io_write)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ioack        <= 1'b0;
         rdata        <= '0;
         frame_out    <= '0;
         frame_strobe <= 1'b0;
         frame_count  <= '0;
         proto_err    <= 1'b0;
      end else begin
         frame_strobe <= done && (op_q == OP_FPUT);
         if (frame_tick)
            frame_count <= frame_count + 1'b1;
         if (set_err)
            proto_err <= 1'b1;
         if (done) begin
            ioack <= 1'b1;
            case (op_q)
               OP_LOAD: rdata     <= in_head;
               OP_FGET: rdata     <= frame_count;
               OP_FPUT: frame_out <= opd_q;
               default: ;
            endcase
         end else if (state_q == ACK && state_d == IDLE) begin
            ioack <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: handshake latency, FIFO stalls, frame
// counter wrap, protocol error and mid-handshake reset.
module tb_io_responder;
   import io_responder_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        io_read = 1'b0, io_write = 1'b0, selframe = 1'b0;
   logic [15:0] wdata = '0;
   logic        ioack;
   logic [15:0] rdata;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready = 1'b0;
   logic        frame_tick = 1'b0;
   logic [15:0] frame_out;
   logic        frame_strobe;
   logic        proto_err;

   int vectors = 0;
   int miscompares = 0;

   io_responder #(.DEPTH(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .io_read      (io_read),
      .io_write     (io_write),
      .selframe     (selframe),
      .wdata        (wdata),
      .ioack        (ioack),
      .rdata        (rdata),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .frame_tick   (frame_tick),
      .frame_out    (frame_out),
      .frame_strobe (frame_strobe),
      .proto_err    (proto_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Full handshake; a non-stalling request must ack on the third edge.
   task automatic do_req(input logic rd, input logic wr, input logic sf,
                         input logic [15:0] wd, input string tag);
      int n;
      n = 0;
      io_read = rd; io_write = wr; selframe = sf; wdata = wd;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (ioack) begin
            n = i;
            break;
         end
      end
      check({tag, "_latency"}, n, 3);
      io_read = 1'b0; io_write = 1'b0; selframe = 1'b0;
      step();
      check({tag, "_release"}, ioack, 0);
   endtask

   initial begin
      #12;
      check("rst_ioack", ioack, 0);
      check("rst_rdata", rdata, 0);
      check("rst_frame_out", frame_out, 0);
      check("rst_strobe", frame_strobe, 0);
      check("rst_proto", proto_err, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      reset = 1'b1;
      step();

      // Load with a word already queued
      in_valid = 1'b1; in_data = 16'h1234;
      step();
      in_valid = 1'b0;
      io_read = 1'b1;
      step();
      check("ld_ack_n", ioack, 0);
      step();
      check("ld_ack_n1", ioack, 0);
      step();
      check("ld_ack_n2", ioack, 1);
      check("ld_rdata", rdata, 16'h1234);
      check("ld_in_count", dut.u_in_fifo.count, 0);
      io_read = 1'b0;
      step();
      check("ld_release", ioack, 0);
      check("ld_rdata_hold", rdata, 16'h1234);
      step();

      // Load stalls on an empty FIFO until the host pushes
      io_read = 1'b1;
      repeat (12) step();
      check("stall_ld_ack", ioack, 0);
      in_valid = 1'b1; in_data = 16'hBEEF;
      step();
      in_valid = 1'b0;
      check("stall_ld_push_edge", ioack, 0);
      step();
      check("stall_ld_ack2", ioack, 1);
      check("stall_ld_rdata", rdata, 16'hBEEF);
      io_read = 1'b0;
      step();
      check("stall_ld_release", ioack, 0);

      // Fill output FIFO, fifth store stalls until one pop
      for (int k = 1; k <= 4; k++)
         do_req(1'b0, 1'b1, 1'b0, 16'(k), "store");
      check("st_count4", dut.u_out_fifo.count, 4);
      check("st_head", out_data, 16'h0001);
      io_write = 1'b1; wdata = 16'h0005;
      repeat (6) step();
      check("st5_stall", ioack, 0);
      check("st5_count", dut.u_out_fifo.count, 4);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("st5_pop_edge", ioack, 0);
      check("st5_count3", dut.u_out_fifo.count, 3);
      step();
      check("st5_ack", ioack, 1);
      check("st5_full", dut.u_out_fifo.count, 4);
      io_write = 1'b0;
      step();
      out_ready = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         check("drain_data", out_data, k);
         step();
      end
      out_ready = 1'b0;
      check("drain_empty", out_valid, 0);

      // Frame counter: get, wrap with coincident tick, put
      frame_tick = 1'b1;
      repeat (3) step();
      frame_tick = 1'b0;
      do_req(1'b1, 1'b0, 1'b1, 16'h0, "fget3");
      check("fget3_rdata", rdata, 16'h0003);
      frame_tick = 1'b1;
      repeat (65532) step();
      frame_tick = 1'b0;
      check("fcount_ffff", dut.frame_count, 16'hFFFF);
      io_read = 1'b1; selframe = 1'b1;
      step();
      step();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("fwrap_ack", ioack, 1);
      check("fwrap_rdata", rdata, 16'hFFFF);
      check("fwrap_count", dut.frame_count, 16'h0000);
      io_read = 1'b0; selframe = 1'b0;
      step();
      io_write = 1'b1; selframe = 1'b1; wdata = 16'h00AA;
      step();
      step();
      check("fput_strobe_pre", frame_strobe, 0);
      step();
      check("fput_ack", ioack, 1);
      check("fput_out", frame_out, 16'h00AA);
      check("fput_strobe", frame_strobe, 1);
      io_write = 1'b0; selframe = 1'b0;
      step();
      check("fput_strobe_post", frame_strobe, 0);
      check("fput_out_hold", frame_out, 16'h00AA);

      // Protocol error: both lines high
      in_valid = 1'b1; in_data = 16'h5555;
      step();
      in_valid = 1'b0;
      do_req(1'b1, 1'b1, 1'b0, 16'h0077, "proto");
      check("proto_flag", proto_err, 1);
      check("proto_in_count", dut.u_in_fifo.count, 1);
      check("proto_out_count", dut.u_out_fifo.count, 0);
      do_req(1'b1, 1'b0, 1'b0, 16'h0, "ld_after_proto");
      check("ld_after_proto_rdata", rdata, 16'h5555);

      // Reset during a stalled store
      for (int k = 1; k <= 4; k++)
         do_req(1'b0, 1'b1, 1'b0, 16'(k + 8), "refill");
      io_write = 1'b1; wdata = 16'h0009;
      repeat (5) step();
      check("rst_wait_state", dut.state_q, WAIT);
      reset = 1'b0;
      #1;
      check("midrst_ioack", ioack, 0);
      check("midrst_state", dut.state_q, IDLE);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_count", dut.u_out_fifo.count, 0);
      check("midrst_proto", proto_err, 0);
      io_write = 1'b0;
      step();
      reset = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
